mem_port_arbiter: RTL

//  Shares the single 32-bit memory port of the multicycle MIPS core between instruction fetch (IF)
//  and data memory (DM). Arbitrates requests, selects the address/write-data source, and holds the

---
 rtl/mips_pkg.sv | 13 +
 rtl/arb_timeout_ctr.sv | 39 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and owner mux-select constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle watchdog: counts stalled cycles since accept and flags the cycle that would
// reach the limit, so the abort lands in the registered outputs one cycle later.
module arb_timeout_ctr #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);
  localparam logic [CntW-1:0] LastVal = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign hit_o = inc_i & ~clr_i & (cnt_q == LastVal);

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory. Holds the port until
// mem_ack, returns registered data and done pulses, and aborts accesses that stall too long.
// Optional macro ARB_FAIR_EN: alternate DM/IF under contention instead of strict DM priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_done,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  import mips_pkg::*;

  arb_state_e  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        err_q, err_d;

  logic        idle, busy, accept, owner, if_wins, tmo_hit;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we;

`ifdef ARB_FAIR_EN
  logic fair_q, fair_d;
  assign if_wins = fair_q;
`else
  assign if_wins = 1'b0;
`endif

  // Grants only in IDLE and never while reset is asserted.
  assign idle   = rst_n & (state_q == ST_IDLE);
  assign busy   = (state_q != ST_IDLE);
  assign dm_gnt = idle & dm_req & ~(if_req & if_wins);
  assign if_gnt = idle & if_req & (~dm_req | if_wins);
  assign accept = if_gnt | dm_gnt;
  assign owner  = dm_gnt ? OWNER_DM : OWNER_IF;

  // 2:1 source select on the owner bit; IF is read-only so its write data is forced to zero.
  assign sel_addr  = (owner == OWNER_DM) ? dm_addr : if_addr;
  assign sel_wdata = (owner == OWNER_DM) ? dm_wdata : 32'h0;
  assign sel_we    = (owner == OWNER_DM) & dm_we;

  arb_timeout_ctr #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (accept),
    .inc_i  (busy & ~mem_ack),
    .hit_o  (tmo_hit)
  );

  // Next-state and registered-output logic; ack beats a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
`ifdef ARB_FAIR_EN
    fair_d      = fair_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = (owner == OWNER_DM) ? ST_BUSY_DM : ST_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
`ifdef ARB_FAIR_EN
          fair_d      = (owner == OWNER_DM);
`endif
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (mem_ack || tmo_hit) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if_done_d = (state_q == ST_BUSY_IF);
          dm_done_d = (state_q == ST_BUSY_DM);
          rdata_d   = (mem_ack && !mem_we_q) ? mem_rdata : 32'h0;
          err_d     = ~mem_ack;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_FAIR_EN
      fair_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
`ifdef ARB_FAIR_EN
      fair_q      <= fair_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;

endmodule
